fft8_stream: RTL

FFT8_STREAM -- requirements
Module: fft8_stream

---
 rtl/fft8_pkg.sv | 49 ++++
 rtl/fft8_bfly.sv | 87 ++++++++
 rtl/fft8_stream.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fft8_pkg.sv
// fft8_pkg: shared constants and helper functions for the 8-point streaming FFT.
// Reduction mode macro: FFT8_SAT_EN (defined: saturate, undefined: wrap to low bits).
package fft8_pkg;

    localparam int unsigned N_PT   = 8;   // points per frame
    localparam int unsigned N_HALF = 4;   // butterflies per stage
    localparam int unsigned RED_W  = 64;  // carrier width for pre-reduction values

    // Bit-reverse table for 3-bit indices: entry k lives at [3*k +: 3].
    localparam logic [23:0] BIT_REV = {3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0};

    // Low bit position of lane k in a packed lane vector.
    function automatic int unsigned lane_lo(input int unsigned k, input int unsigned dw);
        return k * dw;
    endfunction

    // round(0.70711 * 2^(tw-2)): magnitude of the non-trivial W8 twiddle components.
    function automatic int unsigned tw_mag(input int unsigned tw);
        longint unsigned num;
        num = 64'd70711 * (64'd1 << (tw - 2));
        return 32'((num + 64'd50000) / 64'd100000);
    endfunction

    function automatic logic signed [RED_W-1:0] sat_hi(input int unsigned dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [RED_W-1:0] sat_lo(input int unsigned dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

    // True when v is representable as a dw-bit signed value.
    function automatic logic fits(input logic signed [RED_W-1:0] v, input int unsigned dw);
        return (v <= sat_hi(dw)) && (v >= sat_lo(dw));
    endfunction

    // Reduce v to dw bits; result is sign-extended, caller keeps the low dw bits.
    function automatic logic signed [RED_W-1:0] reduce(input logic signed [RED_W-1:0] v,
                                                        input int unsigned dw);
`ifdef FFT8_SAT_EN
        if (v > sat_hi(dw)) return sat_hi(dw);
        if (v < sat_lo(dw)) return sat_lo(dw);
        return v;
`else
        return (v <<< (RED_W - dw)) >>> (RED_W - dw);
`endif
    endfunction

endpackage

// File: rtl/fft8_bfly.sv
// fft8_bfly: one radix-2 DIF butterfly. sum = a + b, dif = (a - b) * W8^tw_sel
// (conjugate twiddle when inv). Reduction follows FFT8_SAT_EN via fft8_pkg::reduce.
module fft8_bfly
    import fft8_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned TW    = 8,
    parameter int unsigned SCALE = 0
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic [1:0]           tw_sel,
    input  logic                 inv,
    output logic signed [DW-1:0] sum_re,
    output logic signed [DW-1:0] sum_im,
    output logic signed [DW-1:0] dif_re,
    output logic signed [DW-1:0] dif_im,
    output logic                 ovf
);

    // Wide enough for the full complex product plus the round constant.
    localparam int unsigned PW  = DW + TW + 2;
    localparam int unsigned RSH = TW - 2;
    localparam int unsigned SH  = (SCALE != 0) ? 1 : 0;
    localparam logic signed [PW-1:0] RND = PW'(1) << (RSH - 1);
    localparam logic signed [PW-1:0] CM  = PW'(tw_mag(TW));

    logic signed [PW-1:0] ar, ai, br, bi;
    logic signed [PW-1:0] sr, si, dr, di;
    logic signed [PW-1:0] wr, wi, pr, pi;
    logic signed [PW-1:0] yr, yi;

    // Add/subtract, rotate the difference, round, then apply the optional stage scaling.
    always_comb begin
        ar = PW'(a_re);
        ai = PW'(a_im);
        br = PW'(b_re);
        bi = PW'(b_im);
        sr = ar + br;
        si = ai + bi;
        dr = ar - br;
        di = ai - bi;
        wr = '0;
        wi = '0;
        pr = '0;
        pi = '0;
        yr = dr;
        yi = di;
        unique case (tw_sel)
            2'd0: begin
                yr = dr;
                yi = di;
            end
            2'd1, 2'd3: begin
                wr = (tw_sel == 2'd1) ? CM : -CM;
                wi = inv ? CM : -CM;
                pr = dr * wr - di * wi + RND;
                pi = dr * wi + di * wr + RND;
                yr = pr >>> RSH;
                yi = pi >>> RSH;
            end
            2'd2: begin
                // Multiply by -j (forward) or +j (inverse): swap and negate.
                yr = inv ? -di : di;
                yi = inv ? dr : -dr;
            end
            default: ;
        endcase
        sr = sr >>> SH;
        si = si >>> SH;
        yr = yr >>> SH;
        yi = yi >>> SH;
    end

    // Narrow to DW bits and flag any value that did not fit.
    always_comb begin
        sum_re = DW'(reduce(RED_W'(sr), DW));
        sum_im = DW'(reduce(RED_W'(si), DW));
        dif_re = DW'(reduce(RED_W'(yr), DW));
        dif_im = DW'(reduce(RED_W'(yi), DW));
        ovf    = !fits(RED_W'(sr), DW) || !fits(RED_W'(si), DW) ||
                 !fits(RED_W'(yr), DW) || !fits(RED_W'(yi), DW);
    end

endmodule

// File: rtl/fft8_stream.sv
// fft8_stream: streaming 8-point radix-2 DIF FFT/IFFT, one frame per cycle.
// Three registered butterfly stages and one output register that undoes bit reversal.
// Reduction mode macro: FFT8_SAT_EN (defined: saturate, undefined: wrap), see fft8_pkg.
module fft8_stream
    import fft8_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned TW    = 8,
    parameter int unsigned SCALE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               inv,
    input  logic [N_PT*DW-1:0] x_re,
    input  logic [N_PT*DW-1:0] x_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_PT*DW-1:0] y_re,
    output logic [N_PT*DW-1:0] y_im,
    output logic               out_inv,
    output logic               ovf,
    input  logic               ovf_clr
);

    logic en;
    logic v1_q, v2_q, v3_q;
    logic i1_q, i2_q, i3_q;
    logic ovf_q, ovf_d;

    logic signed [DW-1:0] x_re_l [N_PT];
    logic signed [DW-1:0] x_im_l [N_PT];
    logic signed [DW-1:0] b1_re [N_PT];
    logic signed [DW-1:0] b1_im [N_PT];
    logic signed [DW-1:0] b2_re [N_PT];
    logic signed [DW-1:0] b2_im [N_PT];
    logic signed [DW-1:0] b3_re [N_PT];
    logic signed [DW-1:0] b3_im [N_PT];
    logic signed [DW-1:0] s1_re_q [N_PT];
    logic signed [DW-1:0] s1_im_q [N_PT];
    logic signed [DW-1:0] s2_re_q [N_PT];
    logic signed [DW-1:0] s2_im_q [N_PT];
    logic signed [DW-1:0] s3_re_q [N_PT];
    logic signed [DW-1:0] s3_im_q [N_PT];
    logic [N_HALF-1:0]    o1, o2, o3;

    // Whole pipeline stalls together only when a presented frame is not taken.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign ovf      = ovf_q;

    for (genvar k = 0; k < N_PT; k++) begin : g_lane
        assign x_re_l[k] = x_re[lane_lo(k, DW) +: DW];
        assign x_im_l[k] = x_im[lane_lo(k, DW) +: DW];
    end

    // Stage 1: pairs (k, k+4), twiddle W8^k.
    for (genvar k = 0; k < N_HALF; k++) begin : g_stg1
        fft8_bfly #(.DW(DW), .TW(TW), .SCALE(SCALE)) u_bfly (
            .a_re   (x_re_l[k]),
            .a_im   (x_im_l[k]),
            .b_re   (x_re_l[k + N_HALF]),
            .b_im   (x_im_l[k + N_HALF]),
            .tw_sel (2'(k)),
            .inv    (inv),
            .sum_re (b1_re[k]),
            .sum_im (b1_im[k]),
            .dif_re (b1_re[k + N_HALF]),
            .dif_im (b1_im[k + N_HALF]),
            .ovf    (o1[k])
        );
    end

    // Stage 2: pairs (k, k+2) inside each half, twiddle W8^0 or W8^2.
    for (genvar j = 0; j < N_HALF; j++) begin : g_stg2
        localparam int unsigned A   = 4 * (j / 2) + (j % 2);
        localparam int unsigned B   = A + 2;
        localparam logic [1:0]  SEL = 2'(2 * (j % 2));
        fft8_bfly #(.DW(DW), .TW(TW), .SCALE(SCALE)) u_bfly (
            .a_re   (s1_re_q[A]),
            .a_im   (s1_im_q[A]),
            .b_re   (s1_re_q[B]),
            .b_im   (s1_im_q[B]),
            .tw_sel (SEL),
            .inv    (i1_q),
            .sum_re (b2_re[A]),
            .sum_im (b2_im[A]),
            .dif_re (b2_re[B]),
            .dif_im (b2_im[B]),
            .ovf    (o2[j])
        );
    end

    // Stage 3: pairs (k, k+1), twiddle W8^0.
    for (genvar j = 0; j < N_HALF; j++) begin : g_stg3
        localparam int unsigned A = 2 * j;
        localparam int unsigned B = A + 1;
        fft8_bfly #(.DW(DW), .TW(TW), .SCALE(SCALE)) u_bfly (
            .a_re   (s2_re_q[A]),
            .a_im   (s2_im_q[A]),
            .b_re   (s2_re_q[B]),
            .b_im   (s2_im_q[B]),
            .tw_sel (2'd0),
            .inv    (i2_q),
            .sum_re (b3_re[A]),
            .sum_im (b3_im[A]),
            .dif_re (b3_re[B]),
            .dif_im (b3_im[B]),
            .ovf    (o3[j])
        );
    end

    // Sticky overflow: clear is applied first so a same-cycle overflow event wins.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (en && ((in_valid && |o1) || (v1_q && |o2) || (v2_q && |o3))) begin
            ovf_d = 1'b1;
        end
    end

    // Valid bits, outputs and overflow flag; cleared at once by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            out_valid <= 1'b0;
            out_inv   <= 1'b0;
            ovf_q     <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
        end else begin
            ovf_q <= ovf_d;
            if (en) begin
                v1_q      <= in_valid;
                v2_q      <= v1_q;
                v3_q      <= v2_q;
                out_valid <= v3_q;
                out_inv   <= i3_q;
                // Stage 3 leaves bins in bit-reversed order; restore natural order.
                for (int k = 0; k < N_PT; k++) begin
                    y_re[k*DW +: DW] <= s3_re_q[BIT_REV[3*k +: 3]];
                    y_im[k*DW +: DW] <= s3_im_q[BIT_REV[3*k +: 3]];
                end
            end
        end
    end

    // Stage data and mode tags; meaningful only where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (en) begin
            i1_q    <= inv;
            i2_q    <= i1_q;
            i3_q    <= i2_q;
            s1_re_q <= b1_re;
            s1_im_q <= b1_im;
            s2_re_q <= b2_re;
            s2_im_q <= b2_im;
            s3_re_q <= b3_re;
            s3_im_q <= b3_im;
        end
    end

endmodule
